// File: rtl/cc_checker.sv
// cc_checker: online checker for the 8-bit enable-gated counter.
// Keeps a golden model of the count and flags, counts and captures every
// divergence between the model and the counter's observed output.
//
// Ports:
//   clk        - clock shared with the counter
//   reset      - asynchronous, active-high reset
//   enable     - counter enable, tapped before any injection point
//   cnt_in     - observed counter value
//   clear      - synchronous clear of all error state, re-enters SYNC
//   err        - one-cycle pulse per detected mismatch
//   err_sticky - set on first mismatch, held until clear/reset
//   err_count  - mismatch count, saturating at MAX_ERR
//   first_exp  - model value at the first mismatch
//   first_obs  - observed value at the first mismatch
//   checking   - high while in CHECK
//
// state | meaning
// SYNC  | load the model from the observed value, no comparison
// CHECK | compare observed value against the model every edge
// HALT  | error limit reached, outputs frozen until clear/reset
module cc_checker #(
    parameter int ERR_W   = 8,
    parameter int MAX_ERR = 255,
    parameter bit RESYNC  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       cnt_in,
    input  logic             clear,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_exp,
    output logic [7:0]       first_obs,
    output logic             checking
);

    localparam logic [ERR_W-1:0] MAX_CNT = ERR_W'(MAX_ERR);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        CHECK = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [7:0]       exp_q, exp_n;
    logic [7:0]       base;
    logic             mismatch;
    logic             err_n;
    logic             sticky_n;
    logic [ERR_W-1:0] count_n;
    logic [7:0]       first_exp_n;
    logic [7:0]       first_obs_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            exp_q      <= 8'd0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            first_exp  <= 8'd0;
            first_obs  <= 8'd0;
            checking   <= 1'b0;
        end else begin
            state      <= state_n;
            exp_q      <= exp_n;
            err        <= err_n;
            err_sticky <= sticky_n;
            err_count  <= count_n;
            first_exp  <= first_exp_n;
            first_obs  <= first_obs_n;
            checking   <= (state_n == CHECK);
        end
    end

    always_comb begin
        state_n     = state;
        exp_n       = exp_q;
        base        = exp_q;
        mismatch    = 1'b0;
        err_n       = 1'b0;
        sticky_n    = err_sticky;
        count_n     = err_count;
        first_exp_n = first_exp;
        first_obs_n = first_obs;

        if (clear) begin
            // Any mismatch in this cycle is discarded.
            state_n     = SYNC;
            sticky_n    = 1'b0;
            count_n     = '0;
            first_exp_n = 8'd0;
            first_obs_n = 8'd0;
        end else begin
            case (state)
                SYNC: begin
                    // Adopt the counter as-is; absorbs reset skew.
                    exp_n   = cnt_in + {7'd0, enable};
                    state_n = CHECK;
                end
                CHECK: begin
                    mismatch = (cnt_in != exp_q);
                    if (mismatch) begin
                        err_n    = 1'b1;
                        sticky_n = 1'b1;
                        if (!err_sticky) begin
                            first_exp_n = exp_q;
                            first_obs_n = cnt_in;
                        end
                        if (err_count != MAX_CNT) begin
                            count_n = err_count + ERR_W'(1);
                        end
                        if (count_n == MAX_CNT) begin
                            state_n = HALT;
                        end
                        if (RESYNC) begin
                            base = cnt_in;
                        end
                    end
                    exp_n = base + {7'd0, enable};
                end
                HALT: begin
                end
                default: begin
                    state_n = SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_checker.sv
// Self-checking bench for cc_checker. Two instances share the stimulus:
// A (RESYNC=1, MAX_ERR=255) and B (RESYNC=0, MAX_ERR=4). A behavioural
// counter with an injectable dropped increment feeds cnt_in, and a reference
// model derived from the counter rule predicts every output each cycle.
module tb_cc_checker;

    localparam int SY = 0;
    localparam int CK = 1;
    localparam int HL = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] cnt_in;
    logic       clear;

    logic       err_a, sticky_a, checking_a;
    logic [7:0] count_a, fexp_a, fobs_a;
    logic       err_b, sticky_b, checking_b;
    logic [7:0] count_b, fexp_b, fobs_b;

    int checks = 0;
    int errors = 0;

    int  ctr;
    bit  drop;
    int  pulses_a, pulses_b;

    int m_mode[2], m_pred[2], m_err[2], m_sticky[2], m_cnt[2], m_fe[2], m_fo[2];
    int m_max[2]  = '{255, 4};
    bit m_rs[2]   = '{1'b1, 1'b0};

    cc_checker #(.ERR_W(8), .MAX_ERR(255), .RESYNC(1'b1)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .cnt_in(cnt_in), .clear(clear),
        .err(err_a), .err_sticky(sticky_a), .err_count(count_a),
        .first_exp(fexp_a), .first_obs(fobs_a), .checking(checking_a)
    );

    cc_checker #(.ERR_W(8), .MAX_ERR(4), .RESYNC(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .cnt_in(cnt_in), .clear(clear),
        .err(err_b), .err_sticky(sticky_b), .err_count(count_b),
        .first_exp(fexp_b), .first_obs(fobs_b), .checking(checking_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear_errs(input int i);
        m_err[i]    = 0;
        m_sticky[i] = 0;
        m_cnt[i]    = 0;
        m_fe[i]     = 0;
        m_fo[i]     = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = SY;
            m_pred[i] = 0;
            model_clear_errs(i);
        end
    endtask

    // One rising edge of the reference model: counter rule cnt' = cnt + en mod 256.
    task automatic model_edge(input bit r, input bit c, input bit e, input int obs);
        int base;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_mode[i] = SY;
                m_pred[i] = 0;
                model_clear_errs(i);
            end else if (c) begin
                m_mode[i] = SY;
                model_clear_errs(i);
            end else if (m_mode[i] == SY) begin
                m_err[i]  = 0;
                m_pred[i] = (obs + int'(e)) % 256;
                m_mode[i] = CK;
            end else if (m_mode[i] == CK) begin
                base = m_pred[i];
                if (obs != m_pred[i]) begin
                    m_err[i] = 1;
                    if (m_sticky[i] == 0) begin
                        m_fe[i] = m_pred[i];
                        m_fo[i] = obs;
                    end
                    m_sticky[i] = 1;
                    m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
                    if (m_cnt[i] == m_max[i]) m_mode[i] = HL;
                    if (m_rs[i]) base = obs;
                end else begin
                    m_err[i] = 0;
                end
                m_pred[i] = (base + int'(e)) % 256;
            end else begin
                m_err[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("a.err",       {7'd0, err_a},      8'(m_err[0]));
        chk("a.sticky",    {7'd0, sticky_a},   8'(m_sticky[0]));
        chk("a.count",     count_a,            8'(m_cnt[0]));
        chk("a.first_exp", fexp_a,             8'(m_fe[0]));
        chk("a.first_obs", fobs_a,             8'(m_fo[0]));
        chk("a.checking",  {7'd0, checking_a}, 8'(m_mode[0] == CK));
        chk("b.err",       {7'd0, err_b},      8'(m_err[1]));
        chk("b.sticky",    {7'd0, sticky_b},   8'(m_sticky[1]));
        chk("b.count",     count_b,            8'(m_cnt[1]));
        chk("b.first_exp", fexp_b,             8'(m_fe[1]));
        chk("b.first_obs", fobs_b,             8'(m_fo[1]));
        chk("b.checking",  {7'd0, checking_b}, 8'(m_mode[1] == CK));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(reset, clear, enable, int'(cnt_in));
        if (enable && !drop) ctr = (ctr + 1) % 256;
        #1;
        cnt_in = 8'(ctr);
        check_all();
        if (err_a) pulses_a++;
        if (err_b) pulses_b++;
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        enable = 1'b0;
        drop   = 1'b0;
        ctr    = 0;
        cnt_in = 8'd0;
        pulses_a = 0;
        pulses_b = 0;
        model_reset();

        // Reset held for 3 cycles.
        #2;
        check_all();
        repeat (3) step();
        reset = 1'b0;

        // Fault-free run with wrap 255 -> 0.
        enable = 1'b1;
        step();
        chk("ff.checking_after_sync", {7'd0, checking_a}, 8'd1);
        repeat (299) step();
        chk("ff.err_pulses", 8'(pulses_a + pulses_b), 8'd0);
        chk("ff.count", count_a, 8'd0);

        // Random enable, fault-free.
        for (int i = 0; i < 100; i++) begin
            enable = 1'($urandom_range(0, 1));
            step();
        end
        chk("rnd.err_pulses", 8'(pulses_a + pulses_b), 8'd0);

        // Single dropped increment: counter holds 0x10 where 0x11 is due.
        clear  = 1'b1;
        enable = 1'b1;
        ctr    = 8'h0E;
        cnt_in = 8'h0E;
        step();
        clear = 1'b0;
        step();
        drop = 1'b1;
        step();
        drop = 1'b0;
        pulses_a = 0;
        pulses_b = 0;
        for (int i = 0; i < 20; i++) begin
            enable = 1'($urandom_range(0, 1));
            step();
        end
        chk("drop.a_pulses",    8'(pulses_a), 8'd1);
        chk("drop.a_count",     count_a,      8'd1);
        chk("drop.a_first_exp", fexp_a,       8'h11);
        chk("drop.a_first_obs", fobs_a,       8'h10);
        chk("drop.b_pulses",    8'(pulses_b), 8'd4);
        chk("drop.b_count",     count_b,      8'd4);
        chk("drop.b_checking",  {7'd0, checking_b}, 8'd0);
        chk("drop.b_first_exp", fexp_b,       8'h11);
        chk("drop.b_first_obs", fobs_b,       8'h10);

        // Asynchronous reset between edges while err_sticky is set.
        chk("arst.pre_sticky", {7'd0, sticky_a}, 8'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("arst.count_zero", count_a, 8'd0);
        ctr    = int'($urandom_range(0, 255));
        cnt_in = 8'(ctr);
        repeat (2) step();
        #2;
        reset = 1'b0;
        enable = 1'b1;
        step();
        chk("arst.no_false_err", {7'd0, err_a | err_b}, 8'd0);
        repeat (4) step();

        // Persistent fault, clear with a coincident mismatch, then saturation.
        drop = 1'b1;
        repeat (10) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (300) step();
        chk("sat.a_count",    count_a, 8'd255);
        chk("sat.a_checking", {7'd0, checking_a}, 8'd0);
        chk("sat.b_count",    count_b, 8'd4);
        clear = 1'b1;
        step();
        chk("clr.a_count",    count_a, 8'd0);
        chk("clr.a_sticky",   {7'd0, sticky_a}, 8'd0);
        chk("clr.a_checking", {7'd0, checking_a}, 8'd0);
        clear = 1'b0;
        drop  = 1'b0;
        step();
        chk("clr.a_checking_after_sync", {7'd0, checking_a}, 8'd1);
        pulses_a = 0;
        pulses_b = 0;
        for (int i = 0; i < 50; i++) begin
            enable = 1'($urandom_range(0, 1));
            step();
        end
        chk("clr.clean_pulses", 8'(pulses_a + pulses_b), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_checker.md
# cc_checker

Online checker for the 8-bit enable-gated counter used as the fault-injection target. It sits on the counter's output side, observes the same `enable` that drives the counter, and keeps a golden model of the count. It flags, counts and captures any divergence between the model and the observed value, so that injected faults on the counter's enable path are detected and logged without a testbench scoreboard.

## Interface
Parameters:
- `ERR_W`, default 8: width of the saturating error counter.
- `MAX_ERR`, default 255: error count at which checking halts. Must be ≤ 2^ERR_W−1 and ≥ 1.
- `RESYNC`, default 1:
  - 1: after a mismatch, the model adopts the observed value.
  - 0: the model keeps its own prediction.

Ports:
- `clk` input 1: single clock, shared with the counter.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: the counter's enable, tapped before any injection point.
- `cnt_in` input 8: the counter's `out`.
- `clear` input 1: synchronous clear of all error state; re-enters SYNC.
- `err` output 1: one-cycle registered pulse per detected mismatch.
- `err_sticky` output 1: set on first mismatch, held until `clear` or `reset`.
- `err_count` output ERR_W: number of mismatches, saturating at MAX_ERR.
- `first_exp` output 8: model value at the first mismatch.
- `first_obs` output 8: observed value at the first mismatch.
- `checking` output 1: high while in the CHECK state.

## Operation
- Model rule: the counter satisfies cnt(k+1) = (cnt(k) + enable(k)) mod 256. Both terms are sampled at the same rising edge.
- Internal register `exp` (8 bits) holds the predicted value of `cnt_in` at the current edge. All arithmetic is mod 256; 255+1 wraps to 0 and is legal.
- The state machine has three states. Reset state is SYNC.
  - SYNC: no comparison is made. `exp <= cnt_in + enable`. Next state is CHECK.
  - CHECK: `mismatch = (cnt_in != exp)`. Let `base` = `cnt_in` if (RESYNC=1 and mismatch), otherwise `exp`. Then `exp <= base + enable`.
  - On mismatch in CHECK:
    - `err <= 1`.
    - `err_count` increments, saturating at MAX_ERR.
    - `err_sticky <= 1`.
    - If `err_sticky` was 0, `first_exp <= exp` and `first_obs <= cnt_in`.
    - If the incremented `err_count` equals MAX_ERR, next state is HALT; otherwise stay in CHECK.
  - HALT: no comparison. `err` is 0 and all other outputs hold. The only exits are `clear` or `reset`.
- `clear` has priority over everything except `reset`. Going from any state:
  - next state is SYNC;
  - `err`, `err_sticky`, `err_count`, `first_exp` and `first_obs` go to 0.
  - A mismatch present in the same cycle as `clear` is discarded.
- `enable` being X/Z is not handled; the counter defines it.

## Timing
- On `reset` assertion, asynchronously and immediately:
  - state = SYNC;
  - `exp`, `err`, `err_sticky`, `err_count`, `first_exp`, `first_obs` = 0;
  - `checking` = 0.
- Reset is asserted mid-operation with the same effect. The first edge after deassertion is the SYNC edge.
- SYNC absorbs any skew between the counter's synchronous reset and this block's asynchronous reset. No false error is allowed on the first edge after reset.
- Latency: a mismatch sampled at edge k gives `err`=1 during the cycle after edge k. `err_count`, `err_sticky`, `first_*` and state updates become visible at the same time.
- `checking` is registered and equals (state == CHECK). It is 0 for the cycle after reset and for the cycle after `clear`.
- Back-to-back mismatches give `err` high on consecutive cycles, with `err_count` incrementing each cycle.
- With RESYNC=1, a single dropped or extra increment gives exactly one `err` pulse. With RESYNC=0, every following cycle mismatches until the values realign.

## Test plan
- Fault-free run:
  - stimulus: reset 3 cycles, then `enable`=1 for 300 cycles (counter wraps 255→0);
  - required: `err` never asserts, `err_count`=0, `checking`=1 from the 2nd edge after reset.
- Single dropped increment, RESYNC=1:
  - stimulus: force `cnt_in` to stay at 0x10 for one edge where 0x11 is expected;
  - required: one `err` pulse, `err_count`=1, `first_exp`=0x11, `first_obs`=0x10, no further errors.
- Same fault, RESYNC=0, counter continuing from the faulty value:
  - required: `err` high every cycle;
  - `err_count` reaches MAX_ERR (set to 4) after 4 cycles, then `checking`=0 (HALT) and `err` stays 0;
  - `first_*` stay 0x11/0x10.
- Saturation/clear:
  - stimulus: MAX_ERR=255 with a persistent fault for 300 cycles, then pulse `clear` in a cycle that also has a mismatch;
  - required: `err_count` holds at 255 in HALT; after `clear` all error outputs are 0, one SYNC cycle, then clean checking.
- Asynchronous reset mid-CHECK:
  - stimulus: assert `reset` between clock edges with `err_sticky`=1;
  - required: all outputs go to 0 before the next edge; no `err` on the first edge after deassertion.
